ns_pkt_histogram: RTL and testbench
===================================

NS_PKT_HISTOGRAM -- requirements
Module: ns_pkt_histogram

Interface
REQ-001 Parameter DW, default 512: monitored tdata width in bits, multiple of 8, 64..1024.
REQ-002 Parameter NUM_BINS, default 4: number of length bins, 1..8.
REQ-003 Parameter CW, default 32: width of each packet counter.
REQ-004 Parameter LW, default 16: width of packet-length arithmetic and config fields.
REQ-005 Parameter MATCH_MODE, default 0: 0 = exact-length match, 1 = ascending threshold ranges.
REQ-006 clk  input  1  sole clock; all logic in this domain.
REQ-007 areset  input  1  asynchronous, active-high reset.
REQ-008 monitor_tdata  input  DW  monitored stream data; ignored.
REQ-009 monitor_tkeep  input  DW/8  byte-valid mask; contiguous from bit 0.
REQ-010 monitor_tlast, monitor_tvalid, monitor_tready  input  1 each  monitored handshake; passive, never driven.
REQ-011 cfg_bin_len  input  NUM_BINS*LW  bin i length/threshold in slice [i*LW +: LW]; quasi-static.
REQ-012 clear_req  input  1  single-cycle pulse; zeroes live statistics.
REQ-013 snap_req  input  1  single-cycle pulse; copies live statistics to snapshot outputs.
REQ-014 bin_count  output  NUM_BINS*CW  live per-bin packet counts, bin i in [i*CW +: CW].
REQ-015 other_count  output  CW  live count of packets matching no bin.
REQ-016 total_bytes  output  64  live byte sum of all completed packets.
REQ-017 min_len, max_len  output  LW each  shortest/longest completed packet length.
REQ-018 snap_bin_count  output  NUM_BINS*CW, snap_other_count  output  CW, snap_total_bytes  output  64  snapshot copies.
REQ-019 snap_valid  output  1  one-cycle pulse, cycle after snapshot registers update.

Function
REQ-020 Beat = cycle with monitor_tvalid & monitor_tready; no other cycle alters length state.
REQ-021 Beat bytes = popcount(monitor_tkeep); packet length = running partial sum + final-beat bytes.
REQ-022 Partial length saturates at 2^LW-1; saturated packets always count as other, never in a bin.
REQ-023 Non-last beat: partial <= packet length; tlast beat: partial <= 0 and packet classified.
REQ-024 MATCH_MODE 0: packet counts in lowest-index bin i with length == cfg_bin_len[i]; else other.
REQ-025 MATCH_MODE 1: lowest-index bin i with length <= cfg_bin_len[i]; else other; cfg ascending by contract.
REQ-026 Exactly one of bin_count/other_count increments per completed packet.
REQ-027 All counters saturate at all-ones; no wrap. total_bytes adds length, saturates at 2^64-1.
REQ-028 min_len <= min(min_len, length); max_len <= max(max_len, length), per completed packet.
REQ-029 Latency: outputs reflect a packet the cycle after its tlast beat (one register stage).
REQ-030 clear_req: live counts/bytes <= 0, min_len <= all-ones, max_len <= 0; partial length NOT cleared.
REQ-031 clear_req coincident with tlast beat: clear applies first; that packet is counted (its bin = 1).
REQ-032 snap_req: snapshot regs take live register values from before this cycle's update.
REQ-033 snap_req with clear_req: snapshot holds pre-clear values; live statistics cleared.
REQ-034 snap_req with tlast beat: completing packet excluded from snapshot, included in live.
REQ-035 snap_valid asserts exactly one cycle, the cycle after snap_req.
REQ-036 Beat with tkeep == 0 adds 0 bytes; tlast with tkeep == 0 still completes packet.

Reset
REQ-037 areset assertion immediately zeroes all counts, bytes, snapshots, partial length, snap_valid.
REQ-038 During reset min_len = all-ones, max_len = 0.
REQ-039 areset mid-packet discards partial; first post-reset tlast counts only post-reset bytes.
REQ-040 Deassertion is synchronised internally to clk before counting resumes (2-stage).

Verification
REQ-041 MODE 0, bins {4160,192,68,64}: 65 full beats + tlast tkeep=0x1 (4161 B) -> other_count=1; 65 beats, final full (4160 B) -> bin_count[0]=1.
REQ-042 MODE 1, thresholds {64,256,1500,9000}: packets 60,64,65,1500,9001 B -> bins {2,1,1,0}, other=1, total_bytes=10690, min=60, max=9001.
REQ-043 CW=4: 17 packets of 68 B into one bin -> count holds 15, no wrap.
REQ-044 snap_req + clear_req in same cycle as a 192 B tlast after 3 prior 192 B packets -> snap bin=3, live bin=1, snap_valid high next cycle only.
REQ-045 areset pulsed after 2 beats of 4096 B packet, then 64 B packet -> 64 B bin=1, other=0.
REQ-046 tvalid high, tready low for 10 cycles with tlast -> no count changes.

Source files
------------

// File: rtl/ns_pkt_histogram.sv
// Passive AXI-Stream packet-length histogram with live statistics and snapshot copies.
// Packets are classified into length bins on their tlast beat; stats update one cycle later.
module ns_pkt_histogram #(
    parameter int DW         = 512,
    parameter int NUM_BINS   = 4,
    parameter int CW         = 32,
    parameter int LW         = 16,
    parameter int MATCH_MODE = 0
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic [DW-1:0]          monitor_tdata,
    input  logic [DW/8-1:0]        monitor_tkeep,
    input  logic                   monitor_tlast,
    input  logic                   monitor_tvalid,
    input  logic                   monitor_tready,
    input  logic [NUM_BINS*LW-1:0] cfg_bin_len,
    input  logic                   clear_req,
    input  logic                   snap_req,
    output logic [NUM_BINS*CW-1:0] bin_count,
    output logic [CW-1:0]          other_count,
    output logic [63:0]            total_bytes,
    output logic [LW-1:0]          min_len,
    output logic [LW-1:0]          max_len,
    output logic [NUM_BINS*CW-1:0] snap_bin_count,
    output logic [CW-1:0]          snap_other_count,
    output logic [63:0]            snap_total_bytes,
    output logic                   snap_valid
);

    localparam int KW = DW / 8;

    logic          unused_tdata;
    logic [1:0]    rst_sync_q;
    logic          rst;

    logic          beat;
    logic          pkt_done;
    logic [LW-1:0] beat_bytes;
    logic [LW:0]   len_sum;
    logic [LW-1:0] pkt_len;
    logic          pkt_sat;
    logic [NUM_BINS-1:0] hit;
    logic          found;

    logic [LW-1:0] partial_q, partial_d;
    logic [CW-1:0] bin_q [NUM_BINS];
    logic [CW-1:0] bin_d [NUM_BINS];
    logic [CW-1:0] other_q, other_d, other_base;
    logic [63:0]   total_q, total_d, total_base;
    logic [64:0]   total_sum;
    logic [LW-1:0] min_q, min_d, min_base;
    logic [LW-1:0] max_q, max_d, max_base;
    logic [CW-1:0] snap_bin_q [NUM_BINS];
    logic [CW-1:0] snap_other_q;
    logic [63:0]   snap_total_q;
    logic          snap_valid_q;

    assign unused_tdata = ^monitor_tdata;

    // Assert immediately with areset, release two clocks after areset drops.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst = rst_sync_q[1];

    assign beat     = monitor_tvalid & monitor_tready;
    assign pkt_done = beat & monitor_tlast;

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < KW; i++) begin
            beat_bytes = beat_bytes + LW'(monitor_tkeep[i]);
        end
    end

    assign len_sum = {1'b0, partial_q} + {1'b0, beat_bytes};
    assign pkt_len = len_sum[LW] ? {LW{1'b1}} : len_sum[LW-1:0];
    assign pkt_sat = &pkt_len;

    always_comb begin
        partial_d = partial_q;
        if (beat) begin
            partial_d = monitor_tlast ? '0 : pkt_len;
        end
    end

    // Lowest-index matching bin wins; saturated lengths never land in a bin.
    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (!found && !pkt_sat) begin
                if (MATCH_MODE == 0) begin
                    if (pkt_len == cfg_bin_len[i*LW +: LW]) begin
                        hit[i] = 1'b1;
                        found  = 1'b1;
                    end
                end else begin
                    if (pkt_len <= cfg_bin_len[i*LW +: LW]) begin
                        hit[i] = 1'b1;
                        found  = 1'b1;
                    end
                end
            end
        end
    end

    // Clear forms the base value, the completing packet is then applied on top.
    always_comb begin
        for (int i = 0; i < NUM_BINS; i++) begin
            bin_d[i] = clear_req ? '0 : bin_q[i];
            if (pkt_done && hit[i] && !(&bin_d[i])) begin
                bin_d[i] = bin_d[i] + 1'b1;
            end
        end
    end

    always_comb begin
        other_base = clear_req ? '0 : other_q;
        total_base = clear_req ? '0 : total_q;
        min_base   = clear_req ? {LW{1'b1}} : min_q;
        max_base   = clear_req ? '0 : max_q;

        other_d = other_base;
        if (pkt_done && !found && !(&other_base)) begin
            other_d = other_base + 1'b1;
        end

        total_sum = {1'b0, total_base} + 65'(pkt_len);
        total_d   = total_base;
        if (pkt_done) begin
            total_d = total_sum[64] ? {64{1'b1}} : total_sum[63:0];
        end

        min_d = min_base;
        max_d = max_base;
        if (pkt_done && (pkt_len < min_base)) begin
            min_d = pkt_len;
        end
        if (pkt_done && (pkt_len > max_base)) begin
            max_d = pkt_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            partial_q    <= '0;
            other_q      <= '0;
            total_q      <= '0;
            min_q        <= {LW{1'b1}};
            max_q        <= '0;
            snap_other_q <= '0;
            snap_total_q <= '0;
            snap_valid_q <= 1'b0;
            for (int i = 0; i < NUM_BINS; i++) begin
                bin_q[i]      <= '0;
                snap_bin_q[i] <= '0;
            end
        end else begin
            partial_q    <= partial_d;
            other_q      <= other_d;
            total_q      <= total_d;
            min_q        <= min_d;
            max_q        <= max_d;
            snap_valid_q <= snap_req;
            for (int i = 0; i < NUM_BINS; i++) begin
                bin_q[i] <= bin_d[i];
            end
            // Snapshot samples the registered values, i.e. before this cycle's clear/packet.
            if (snap_req) begin
                snap_other_q <= other_q;
                snap_total_q <= total_q;
                for (int i = 0; i < NUM_BINS; i++) begin
                    snap_bin_q[i] <= bin_q[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_BINS; g++) begin : g_pack
        assign bin_count[g*CW +: CW]      = bin_q[g];
        assign snap_bin_count[g*CW +: CW] = snap_bin_q[g];
    end

    assign other_count      = other_q;
    assign total_bytes      = total_q;
    assign min_len          = min_q;
    assign max_len          = max_q;
    assign snap_other_count = snap_other_q;
    assign snap_total_bytes = snap_total_q;
    assign snap_valid       = snap_valid_q;

endmodule

// File: tb/tb_ns_pkt_histogram.sv
// Directed bench: exact-match instance (CW=32) and threshold instance (CW=4) share one monitored bus.
module tb_ns_pkt_histogram;

    logic         clk;
    logic         areset;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic         tlast;
    logic         tvalid;
    logic         tready;
    logic         clear_req;
    logic         snap_req;
    logic [63:0]  a_cfg;
    logic [63:0]  b_cfg;

    logic [127:0] a_bin, a_sbin;
    logic [31:0]  a_other, a_sother;
    logic [63:0]  a_tot, a_stot;
    logic [15:0]  a_min, a_max;
    logic         a_sv;

    logic [15:0]  b_bin, b_sbin;
    logic [3:0]   b_other, b_sother;
    logic [63:0]  b_tot, b_stot;
    logic [15:0]  b_min, b_max;
    logic         b_sv;

    int n_cmp = 0;
    int n_err = 0;

    ns_pkt_histogram #(.DW(512), .NUM_BINS(4), .CW(32), .LW(16), .MATCH_MODE(0)) u_dut_a (
        .clk(clk), .areset(areset), .monitor_tdata(tdata), .monitor_tkeep(tkeep),
        .monitor_tlast(tlast), .monitor_tvalid(tvalid), .monitor_tready(tready),
        .cfg_bin_len(a_cfg), .clear_req(clear_req), .snap_req(snap_req),
        .bin_count(a_bin), .other_count(a_other), .total_bytes(a_tot),
        .min_len(a_min), .max_len(a_max), .snap_bin_count(a_sbin),
        .snap_other_count(a_sother), .snap_total_bytes(a_stot), .snap_valid(a_sv)
    );

    ns_pkt_histogram #(.DW(512), .NUM_BINS(4), .CW(4), .LW(16), .MATCH_MODE(1)) u_dut_b (
        .clk(clk), .areset(areset), .monitor_tdata(tdata), .monitor_tkeep(tkeep),
        .monitor_tlast(tlast), .monitor_tvalid(tvalid), .monitor_tready(tready),
        .cfg_bin_len(b_cfg), .clear_req(clear_req), .snap_req(snap_req),
        .bin_count(b_bin), .other_count(b_other), .total_bytes(b_tot),
        .min_len(b_min), .max_len(b_max), .snap_bin_count(b_sbin),
        .snap_other_count(b_sother), .snap_total_bytes(b_stot), .snap_valid(b_sv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One beat of n valid bytes; returns 1 time unit after the sampling edge.
    task automatic beat(input int n, input logic last, input logic snap, input logic clr);
        tkeep     = (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        tvalid    = 1'b1;
        tready    = 1'b1;
        tlast     = last;
        snap_req  = snap;
        clear_req = clr;
        @(posedge clk);
        #1;
        tvalid    = 1'b0;
        tlast     = 1'b0;
        snap_req  = 1'b0;
        clear_req = 1'b0;
        tkeep     = '0;
    endtask

    task automatic send_pkt(input int bytes, input logic snap, input logic clr);
        int nfull;
        nfull = (bytes - 1) / 64;
        for (int i = 0; i < nfull; i++) beat(64, 1'b0, 1'b0, 1'b0);
        beat(bytes - 64 * nfull, 1'b1, snap, clr);
    endtask

    task automatic do_clear();
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
    endtask

    initial begin
        areset    = 1'b0;
        tdata     = {16{32'hdead_beef}};
        tkeep     = '0;
        tlast     = 1'b0;
        tvalid    = 1'b0;
        tready    = 1'b0;
        clear_req = 1'b0;
        snap_req  = 1'b0;
        a_cfg     = {16'd64, 16'd68, 16'd192, 16'd4160};
        b_cfg     = {16'd9000, 16'd1500, 16'd256, 16'd64};
        #2 areset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_a_bin_lo", a_bin[63:0], 64'd0);
        check_val("rst_a_min", a_min, 64'hffff);
        check_val("rst_a_max", a_max, 64'd0);
        check_val("rst_a_snap_valid", a_sv, 64'd0);
        check_val("rst_b_other", b_other, 64'd0);
        areset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Exact-match boundary: 4161 B misses bin 0, 4160 B hits it.
        send_pkt(4161, 1'b0, 1'b0);
        check_val("a_4161_other", a_other, 64'd1);
        check_val("a_4161_bin0", a_bin[31:0], 64'd0);
        send_pkt(4160, 1'b0, 1'b0);
        check_val("a_4160_bin0", a_bin[31:0], 64'd1);
        check_val("a_total", a_tot, 64'd8321);
        check_val("a_min", a_min, 64'd4160);
        check_val("a_max", a_max, 64'd4161);

        // Threshold ranges.
        do_clear();
        check_val("a_clear_min", a_min, 64'hffff);
        check_val("a_clear_other", a_other, 64'd0);
        send_pkt(60, 1'b0, 1'b0);
        send_pkt(64, 1'b0, 1'b0);
        send_pkt(65, 1'b0, 1'b0);
        send_pkt(1500, 1'b0, 1'b0);
        send_pkt(9001, 1'b0, 1'b0);
        check_val("b_bin0", b_bin[3:0], 64'd2);
        check_val("b_bin1", b_bin[7:4], 64'd1);
        check_val("b_bin2", b_bin[11:8], 64'd1);
        check_val("b_bin3", b_bin[15:12], 64'd0);
        check_val("b_other", b_other, 64'd1);
        check_val("b_total", b_tot, 64'd10690);
        check_val("b_min", b_min, 64'd60);
        check_val("b_max", b_max, 64'd9001);
        check_val("a_mix_bin3", a_bin[127:96], 64'd1);
        check_val("a_mix_other", a_other, 64'd4);

        // Counter saturation on the 4-bit instance.
        do_clear();
        for (int k = 0; k < 17; k++) send_pkt(68, 1'b0, 1'b0);
        check_val("b_sat_bin1", b_bin[7:4], 64'd15);
        check_val("a_68_bin2", a_bin[95:64], 64'd17);

        // Snap + clear coincident with a completing packet.
        do_clear();
        for (int k = 0; k < 3; k++) send_pkt(192, 1'b0, 1'b0);
        send_pkt(192, 1'b1, 1'b1);
        check_val("a_snap_bin1", a_sbin[63:32], 64'd3);
        check_val("a_snap_total", a_stot, 64'd576);
        check_val("a_live_bin1", a_bin[63:32], 64'd1);
        check_val("a_live_total", a_tot, 64'd192);
        check_val("a_snap_valid_hi", a_sv, 64'd1);
        @(posedge clk);
        #1;
        check_val("a_snap_valid_lo", a_sv, 64'd0);

        // Stalled bus: tvalid with tready low must be ignored.
        tvalid = 1'b1;
        tready = 1'b0;
        tlast  = 1'b1;
        tkeep  = {64{1'b1}};
        repeat (10) @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tkeep  = '0;
        check_val("a_stall_bin1", a_bin[63:32], 64'd1);
        check_val("a_stall_total", a_tot, 64'd192);
        check_val("a_stall_other", a_other, 64'd0);
        send_pkt(64, 1'b0, 1'b0);
        check_val("a_post_stall_bin3", a_bin[127:96], 64'd1);

        // Reset mid-packet.
        beat(64, 1'b0, 1'b0, 1'b0);
        beat(64, 1'b0, 1'b0, 1'b0);
        areset = 1'b1;
        #1;
        check_val("a_arst_bin3", a_bin[127:96], 64'd0);
        check_val("a_arst_total", a_tot, 64'd0);
        check_val("a_arst_snap_bin1", a_sbin[63:32], 64'd0);
        check_val("a_arst_min", a_min, 64'hffff);
        @(posedge clk);
        #1;
        areset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send_pkt(64, 1'b0, 1'b0);
        check_val("a_postrst_bin3", a_bin[127:96], 64'd1);
        check_val("a_postrst_other", a_other, 64'd0);
        check_val("a_postrst_total", a_tot, 64'd64);

        // Zero-byte tlast beat still completes the packet.
        beat(64, 1'b0, 1'b0, 1'b0);
        beat(0, 1'b1, 1'b0, 1'b0);
        check_val("a_keep0_bin3", a_bin[127:96], 64'd2);
        check_val("a_keep0_total", a_tot, 64'd128);

        // Length saturation forces other.
        do_clear();
        send_pkt(65600, 1'b0, 1'b0);
        check_val("b_lsat_other", b_other, 64'd1);
        check_val("b_lsat_max", b_max, 64'hffff);
        check_val("a_lsat_other", a_other, 64'd1);
        check_val("a_lsat_total", a_tot, 64'd65535);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
